// File: rtl/cpu_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with a strobe-toggle handshake.
// Optional build macro: CPU_MULDIV_EARLY_OUT_EN enables the |op1| < |op2| divide early-out.
module cpu_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS    = 1
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_strobe,
  input  logic            i_abort,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_busy,
  output logic            o_strobe,
  output logic [XLEN-1:0] o_result
);

  localparam int K       = XLEN / DIV_BITS;
  localparam int CNT_MAX = (K > MUL_LATENCY) ? K : MUL_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t          state_q;
  logic            acc_strobe_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [CW-1:0]   cnt_q;

  assign o_busy = (i_strobe != o_strobe) && !i_abort;

  // Accept-time decode: signedness, magnitudes and the divide special cases.
  logic            in_signed;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            div_ovf;
  logic            early_out;

  assign in_signed = ~i_op[0];
  assign sign1     = in_signed & i_op1[XLEN-1];
  assign sign2     = in_signed & i_op2[XLEN-1];
  assign mag1      = sign1 ? -i_op1 : i_op1;
  assign mag2      = sign2 ? -i_op2 : i_op2;
  assign div_zero  = (i_op2 == '0);
  assign div_ovf   = in_signed & (i_op1 == MIN_VAL) & (i_op2 == '1);

`ifdef CPU_MULDIV_EARLY_OUT_EN
  assign early_out = ~div_zero & (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  // Full 2*XLEN product of the sign-extended latched operands.
  logic              mul_sa;
  logic              mul_sb;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_result;
  logic [XLEN-1:0]   fix_result;

  assign mul_sa     = (op_q == 3'd1) | (op_q == 3'd2);
  assign mul_sb     = (op_q == 3'd1);
  assign mul_a      = {{XLEN{mul_sa & opa_q[XLEN-1]}}, opa_q};
  assign mul_b      = {{XLEN{mul_sb & opb_q[XLEN-1]}}, opb_q};
  assign product    = mul_a * mul_b;
  assign mul_result = (op_q == 3'd0) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  assign fix_result = op_q[1] ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);

  // One restoring-division iteration retiring DIV_BITS quotient bits.
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] rem_n;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_n = quo_q;
    rem_n = rem_q;
    trial = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {rem_n, quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial    = trial - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[XLEN-1:0];
    end
  end

  // Divide fast paths preload quo/rem with unsigned flags and go straight to the fix cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      acc_strobe_q <= 1'b0;
      o_strobe     <= 1'b0;
      o_result     <= '0;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      dvs_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      cnt_q        <= '0;
    end else if (i_abort) begin
      state_q      <= S_IDLE;
      acc_strobe_q <= i_strobe;
      o_strobe     <= i_strobe;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_strobe != acc_strobe_q) begin
            acc_strobe_q <= i_strobe;
            op_q         <= i_op;
            opa_q        <= i_op1;
            opb_q        <= i_op2;
            if (!i_op[2]) begin
              state_q <= S_MUL;
              cnt_q   <= CW'(MUL_LATENCY - 1);
            end else begin
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              if (div_zero) begin
                quo_q   <= '1;
                rem_q   <= i_op1;
                state_q <= S_FIX;
              end else if (div_ovf) begin
                quo_q   <= MIN_VAL;
                rem_q   <= '0;
                state_q <= S_FIX;
              end else if (early_out) begin
                quo_q   <= '0;
                rem_q   <= i_op1;
                state_q <= S_FIX;
              end else begin
                quo_q     <= mag1;
                rem_q     <= '0;
                dvs_q     <= mag2;
                neg_quo_q <= sign1 ^ sign2;
                neg_rem_q <= sign1;
                cnt_q     <= CW'(K);
                state_q   <= S_DIV;
              end
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            o_result <= mul_result;
            o_strobe <= ~o_strobe;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          quo_q <= quo_n;
          rem_q <= rem_n;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          o_result <= fix_result;
          o_strobe <= ~o_strobe;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// Self-checking bench for cpu_muldiv_unit at XLEN=32, MUL_LATENCY=2, DIV_BITS=1.
// Directed vectors with literal expectations plus a per-cycle reference-model compare.
`timescale 1ns/1ps
module tb_cpu_muldiv_unit;

  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 2;
  localparam int DIV_BITS    = 1;
  localparam int DIV_CYCLES  = XLEN / DIV_BITS + 1;
  localparam int BUDGET      = 100;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_strobe;
  logic        i_abort;
  logic [2:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_busy;
  logic        o_strobe;
  logic [31:0] o_result;

  int   compared   = 0;
  int   mismatched = 0;
  logic check_en   = 1'b0;

  always #5 i_clock = ~i_clock;

  cpu_muldiv_unit #(
    .XLEN        (XLEN),
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_BITS    (DIV_BITS)
  ) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_strobe (i_strobe),
    .i_abort  (i_abort),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .o_busy   (o_busy),
    .o_strobe (o_strobe),
    .o_result (o_result)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural result using plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  // Accept-to-result edge count for an operation.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (!op[2]) return MUL_LATENCY;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef CPU_MULDIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return DIV_CYCLES;
`endif
    return DIV_CYCLES;
  endfunction

  // Transaction-level model: one op in flight, completing a fixed number of edges after accept.
  logic        m_acc;
  logic        m_busy;
  logic        exp_strobe;
  logic [31:0] exp_result;
  logic [31:0] m_val;
  int          m_left;

  always @(posedge i_clock) begin
    if (i_reset) begin
      m_acc      <= 1'b0;
      m_busy     <= 1'b0;
      exp_strobe <= 1'b0;
      exp_result <= '0;
      m_val      <= '0;
      m_left     <= 0;
    end else if (i_abort) begin
      m_busy     <= 1'b0;
      m_acc      <= i_strobe;
      exp_strobe <= i_strobe;
    end else if (m_busy) begin
      if (m_left == 1) begin
        exp_result <= m_val;
        exp_strobe <= ~exp_strobe;
        m_busy     <= 1'b0;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (i_strobe != m_acc) begin
      m_acc  <= i_strobe;
      m_val  <= ref_result(i_op, i_op1, i_op2);
      m_left <= ref_latency(i_op, i_op1, i_op2);
      m_busy <= 1'b1;
    end
  end

  always @(negedge i_clock) begin
    if (check_en) begin
      checkOutput("model_strobe", {31'd0, o_strobe}, {31'd0, exp_strobe});
      checkOutput("model_result", o_result, exp_result);
      checkOutput("model_busy", {31'd0, o_busy}, {31'd0, (i_strobe != exp_strobe) && !i_abort});
    end
  end

  // Issue one request from a negedge and wait (bounded) for its completion toggle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    #1;
    i_op     = op;
    i_op1    = a;
    i_op2    = b;
    i_strobe = ~i_strobe;
    @(posedge i_clock);
    lat = 0;
    while (lat < BUDGET) begin
      @(posedge i_clock);
      lat++;
      @(negedge i_clock);
      if (o_strobe == i_strobe) break;
    end
    if (o_strobe != i_strobe) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: op %0d got no completion within %0d cycles, required one", op, BUDGET);
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expected, input int expected_lat);
    int lat;
    applyStimulus(op, a, b, lat);
    checkOutput({name, "_result"}, o_result, expected);
    checkOutput({name, "_latency"}, lat, expected_lat);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        prev_strobe;
    logic [31:0] prev_result;
    i_reset  = 1'b1;
    i_strobe = 1'b0;
    i_abort  = 1'b0;
    i_op     = '0;
    i_op1    = '0;
    i_op2    = '0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    #1 i_reset = 1'b0;
    check_en = 1'b1;
    @(negedge i_clock);
    checkOutput("reset_strobe", {31'd0, o_strobe}, 32'd0);
    checkOutput("reset_result", o_result, 32'd0);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);

    // Hand-computed pins on the reference model itself.
    checkOutput("pin_mulh", ref_result(3'd1, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFFF);
    checkOutput("pin_div", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    checkOutput("pin_rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    checkOutput("pin_divlat", ref_latency(3'd5, 32'd100, 32'd7), 32'd33);

    runOp("mulh_neg", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 2);
    runOp("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    runOp("mul_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
    runOp("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    runOp("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runOp("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runOp("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    runOp("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    runOp("div_negdivisor", 3'd4, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    runOp("rem_negdivisor", 3'd6, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    runOp("div_by_zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("remu_by_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    runOp("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`ifdef CPU_MULDIV_EARLY_OUT_EN
    runOp("divu_small", 3'd5, 32'd3, 32'd10, 32'd0, 1);
`else
    runOp("divu_small", 3'd5, 32'd3, 32'd10, 32'd0, 33);
`endif

    // Abort a long divide at E0+10 while upstream withdraws its request.
    prev_strobe = o_strobe;
    prev_result = o_result;
    #1;
    i_op     = 3'd4;
    i_op1    = 32'd1000;
    i_op2    = 32'd3;
    i_strobe = ~i_strobe;
    @(posedge i_clock);
    repeat (9) @(posedge i_clock);
    @(negedge i_clock);
    #1;
    i_abort  = 1'b1;
    i_strobe = ~i_strobe;
    @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("abort_strobe", {31'd0, o_strobe}, {31'd0, prev_strobe});
    checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
    #1 i_abort = 1'b0;
    repeat (40) @(negedge i_clock);
    checkOutput("abort_no_toggle", {31'd0, o_strobe}, {31'd0, prev_strobe});
    checkOutput("abort_result_held", o_result, prev_result);

    runOp("mul_after_abort", 3'd0, 32'd6, 32'd7, 32'd42, 2);

    // Synchronous reset in the middle of a divide discards it.
    #1;
    i_op     = 3'd5;
    i_op1    = 32'd1000;
    i_op2    = 32'd3;
    i_strobe = ~i_strobe;
    repeat (6) @(posedge i_clock);
    @(negedge i_clock);
    #1;
    i_reset  = 1'b1;
    i_strobe = 1'b0;
    @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("midop_reset_strobe", {31'd0, o_strobe}, 32'd0);
    checkOutput("midop_reset_result", o_result, 32'd0);
    #1 i_reset = 1'b0;
    repeat (40) @(negedge i_clock);
    checkOutput("midop_reset_quiet", {31'd0, o_strobe}, 32'd0);

    runOp("divu_after_reset", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
